// File: rtl/bnn_maxpool_if.sv
// Bundle of the pooling engine's control handshake and its SRAM read/write ports.
// The slave side is the pooling engine; the master side drives run and returns read data.
interface bnn_maxpool_if #(
  parameter int ADDR_W = 12
);
  logic              run;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] dut_sram_read_address;
  logic [15:0]       sram_dut_read_data;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic [15:0]       dut_sram_write_data;
  logic              wr_enable;

  modport slave (
    input  run,
    input  sram_dut_read_data,
    output busy,
    output done,
    output err,
    output dut_sram_read_address,
    output dut_sram_write_address,
    output dut_sram_write_data,
    output wr_enable
  );

  modport master (
    output run,
    output sram_dut_read_data,
    input  busy,
    input  done,
    input  err,
    input  dut_sram_read_address,
    input  dut_sram_write_address,
    input  dut_sram_write_data,
    input  wr_enable
  );
endinterface

// File: rtl/bnn_maxpool.sv
// 2x2 max-pool (bitwise OR) of a binary feature map held in SRAM: reads a D x D
// map (header word D, one 16-bit row per word) and writes the P x P pooled map at OUT_BASE.
module bnn_maxpool #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(12'h800)
) (
  input  logic             clk,
  input  logic             reset,
  bnn_maxpool_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_A,
    HDR_D,
    ROW_A,
    ROW_B,
    ROW_D,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;
  logic [2:0]        p_q;
  logic [2:0]        np_q;
  logic [15:0]       row_even_q;
  logic [15:0]       row_odd_q;

  // Only the three map sizes the downstream layers are built for are accepted.
  function automatic logic dim_valid(input logic [15:0] d);
    return (d == 16'd8) || (d == 16'd10) || (d == 16'd14);
  endfunction

  // Pooled bit j covers columns 2j/2j+1 of both rows; bits at or above P stay 0,
  // which also keeps any input bits at or above D out of the result.
  function automatic logic [15:0] pool_row_pair(input logic [15:0] a,
                                                input logic [15:0] b,
                                                input logic [2:0]  np);
    logic [15:0] v;
    logic [15:0] o;
    v = a | b;
    o = '0;
    for (int j = 0; j < 8; j++) begin
      if (j < int'(np)) begin
        o[j] = v[2*j] | v[2*j+1];
      end
    end
    return o;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      p_q        <= '0;
      np_q       <= '0;
      row_even_q <= '0;
      row_odd_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.run) begin
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            rd_addr_q <= '0;
            state     <= HDR_A;
          end
        end
        HDR_A: begin
          state <= HDR_D;
        end
        HDR_D: begin
          if (dim_valid(bus.sram_dut_read_data)) begin
            np_q      <= bus.sram_dut_read_data[3:1];
            wr_addr_q <= OUT_BASE;
            wr_data_q <= {13'd0, bus.sram_dut_read_data[3:1]};
            wr_en_q   <= 1'b1;
            rd_addr_q <= ADDR_W'(1);
            p_q       <= '0;
            state     <= ROW_A;
          end else begin
            err_q <= 1'b1;
            state <= DONE;
          end
        end
        // Row 2p lives at address 2p+1, so its partner row 2p+1 is at 2p+2.
        ROW_A: begin
          rd_addr_q <= ADDR_W'({p_q, 1'b0}) + ADDR_W'(2);
          state     <= ROW_B;
        end
        ROW_B: begin
          row_even_q <= bus.sram_dut_read_data;
          state      <= ROW_D;
        end
        ROW_D: begin
          row_odd_q <= bus.sram_dut_read_data;
          state     <= WRITE;
        end
        WRITE: begin
          wr_addr_q <= OUT_BASE + ADDR_W'(1) + ADDR_W'(p_q);
          wr_data_q <= pool_row_pair(row_even_q, row_odd_q, np_q);
          wr_en_q   <= 1'b1;
          if (p_q == np_q - 3'd1) begin
            state <= DONE;
          end else begin
            p_q       <= p_q + 3'd1;
            rd_addr_q <= ADDR_W'({p_q, 1'b1}) + ADDR_W'(2);
            state     <= ROW_A;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy                   = busy_q;
  assign bus.done                   = done_q;
  assign bus.err                    = err_q;
  assign bus.wr_enable              = wr_en_q;
  assign bus.dut_sram_read_address  = rd_addr_q;
  assign bus.dut_sram_write_address = wr_addr_q;
  assign bus.dut_sram_write_data    = wr_data_q;

endmodule

// File: tb/tb_bnn_maxpool.sv
// Bench for bnn_maxpool: SRAM model, write scoreboard and directed/random map runs.
module tb_bnn_maxpool;
  localparam int          ADDR_W   = 12;
  localparam logic [11:0] OUT_BASE = 12'h800;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bnn_maxpool_if #(.ADDR_W(ADDR_W)) bus ();

  bnn_maxpool #(.ADDR_W(ADDR_W), .OUT_BASE(OUT_BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem  [0:4095];
  logic [15:0] wlog [0:4095];
  logic [27:0] exp_q [$];
  logic [11:0] wseq [$];
  int n_chk = 0;
  int n_fail = 0;
  int wcount = 0;
  int exp_pushed = 0;

  always @(posedge clk) bus.sram_dut_read_data <= mem[bus.dut_sram_read_address];

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Write monitor: every strobe is matched against the oldest expected write.
  always @(negedge clk) begin
    if (bus.wr_enable === 1'b1) begin
      logic [27:0] e;
      wcount++;
      wlog[bus.dut_sram_write_address] = bus.dut_sram_write_data;
      wseq.push_back(bus.dut_sram_write_address);
      chk_eq("wr_not_expected", 32'(wcount <= exp_pushed), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_eq("wr_addr", 32'(bus.dut_sram_write_address), 32'(e[27:16]));
        chk_eq("wr_data", 32'(bus.dut_sram_write_data), 32'(e[15:0]));
      end
    end
  end

  function automatic logic [15:0] model_row(input int d, input int p);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    a = mem[1 + 2*p];
    b = mem[2 + 2*p];
    r = '0;
    for (int j = 0; j < d/2; j++) r[j] = a[2*j] | a[2*j+1] | b[2*j] | b[2*j+1];
    return r;
  endfunction

  function automatic bit is_valid(input int d);
    return (d == 8) || (d == 10) || (d == 14);
  endfunction

  task automatic push_expect(input int d);
    if (is_valid(d)) begin
      exp_q.push_back({OUT_BASE, 16'(d/2)});
      for (int p = 0; p < d/2; p++) exp_q.push_back({12'(OUT_BASE + 12'(1 + p)), model_row(d, p)});
      exp_pushed += d/2 + 1;
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 4096; i++) wlog[i] = 16'hDEAD;
    wseq.delete();
  endtask

  // Called at a negedge with the DUT idle; poke>0 pulses run at that cycle of the busy window.
  task automatic do_run(input int d, input string tag, input int poke);
    int cyc;
    int base;
    int np;
    np = d / 2;
    base = wcount;
    mem[0] = 16'(d);
    push_expect(d);
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    cyc = 1;
    chk_eq({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    chk_eq({tag, "_err_cleared"}, 32'(bus.err), 32'd0);
    while (bus.done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.run = (cyc == poke) ? 1'b1 : 1'b0;
    end
    bus.run = 1'b0;
    chk_eq({tag, "_cycles"}, 32'(cyc), is_valid(d) ? 32'(4*np + 4) : 32'd4);
    chk_eq({tag, "_err"}, 32'(bus.err), is_valid(d) ? 32'd0 : 32'd1);
    chk_eq({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    chk_eq({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    repeat (8) @(negedge clk);
    chk_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk_eq({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk_eq({tag, "_err_held"}, 32'(bus.err), is_valid(d) ? 32'd0 : 32'd1);
    chk_eq({tag, "_writes"}, 32'(wcount - base), is_valid(d) ? 32'(np + 1) : 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    int sizes [3];
    sizes = '{8, 10, 14};
    bus.run = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    clear_logs();

    // Reset state, and reset taking priority over run.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    bus.run = 1'b1;
    @(negedge clk);
    chk_eq("rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("rst_done", 32'(bus.done), 32'd0);
    chk_eq("rst_err", 32'(bus.err), 32'd0);
    chk_eq("rst_wr_en", 32'(bus.wr_enable), 32'd0);
    chk_eq("rst_rd_addr", 32'(bus.dut_sram_read_address), 32'd0);
    chk_eq("rst_wr_addr", 32'(bus.dut_sram_write_address), 32'd0);
    chk_eq("rst_wr_data", 32'(bus.dut_sram_write_data), 32'd0);
    bus.run = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // D=8, alternating rows.
    clear_logs();
    for (int r = 1; r <= 8; r++) mem[r] = (r % 2 == 1) ? 16'h00AA : 16'h0055;
    do_run(8, "d8_alt", 0);
    chk_eq("d8_alt_hdr", 32'(wlog[12'h800]), 32'h0004);
    for (int p = 0; p < 4; p++) chk_eq("d8_alt_row", 32'(wlog[12'(12'h801 + p)]), 32'h000F);

    // D=14, single set bit in row 5 column 13.
    clear_logs();
    for (int r = 1; r <= 14; r++) mem[r] = 16'h0000;
    mem[6] = 16'h2000;
    do_run(14, "d14_bit", 0);
    chk_eq("d14_hdr", 32'(wlog[12'h800]), 32'h0007);
    for (int p = 0; p < 7; p++)
      chk_eq("d14_row", 32'(wlog[12'(12'h801 + p)]), (p == 2) ? 32'h0040 : 32'h0000);

    // D=10, only bits beyond the map width set.
    clear_logs();
    for (int r = 1; r <= 10; r++) mem[r] = 16'hFC00;
    do_run(10, "d10_hi", 0);
    chk_eq("d10_hdr", 32'(wlog[12'h800]), 32'h0005);
    for (int p = 0; p < 5; p++) chk_eq("d10_row", 32'(wlog[12'(12'h801 + p)]), 32'h0000);

    // Invalid headers.
    do_run(12, "d12_bad", 0);
    do_run(0, "d0_bad", 0);
    do_run(9, "d9_bad", 0);
    do_run(16, "d16_bad", 0);

    // Random maps, including noise in the ignored high bits.
    for (int t = 0; t < 9; t++) begin
      for (int r = 1; r <= 14; r++) mem[r] = 16'($urandom);
      do_run(sizes[t % 3], "rand", 0);
    end

    // Reset in the cycle the second write is on the bus.
    for (int r = 1; r <= 8; r++) mem[r] = 16'($urandom);
    mem[0] = 16'd8;
    base = wcount;
    push_expect(8);
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    cyc = 0;
    #1;
    while (wcount < base + 2 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk_eq("abort_second_write_seen", 32'(wcount - base), 32'd2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("abort_wr_en", 32'(bus.wr_enable), 32'd0);
    chk_eq("abort_busy", 32'(bus.busy), 32'd0);
    chk_eq("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_pushed = wcount;
    base = wcount;
    repeat (30) @(negedge clk);
    chk_eq("abort_no_more_writes", 32'(wcount - base), 32'd0);
    clear_logs();
    do_run(8, "after_abort", 0);
    chk_eq("after_abort_first_addr", (wseq.size() > 0) ? 32'(wseq[0]) : 32'hFFFF_FFFF, 32'(OUT_BASE));

    // run pulsed mid-operation is ignored.
    for (int r = 1; r <= 10; r++) mem[r] = 16'($urandom);
    do_run(10, "poke", 6);

    // run held high: second pass starts right after the done pulse.
    for (int r = 1; r <= 8; r++) mem[r] = 16'($urandom);
    mem[0] = 16'd8;
    base = wcount;
    push_expect(8);
    push_expect(8);
    bus.run = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk_eq("hold_pass1_cycles", 32'(cyc), 32'd20);
    @(negedge clk);
    bus.run = 1'b0;
    chk_eq("hold_restart_busy", 32'(bus.busy), 32'd1);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk_eq("hold_pass2_cycles", 32'(cyc), 32'd20);
    repeat (8) @(negedge clk);
    chk_eq("hold_writes", 32'(wcount - base), 32'd10);
    chk_eq("hold_busy_after", 32'(bus.busy), 32'd0);
    chk_eq("hold_queue_left", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
